i2c_target: RTL and testbench
=============================

Name: i2c_target

Overview:
- I2C slave (target) for the audio shield. It is the responder end of the existing `i2c` master, so bench and board loop-back can drive the master against it.
- Decodes START, STOP and repeated START, matches a 7-bit address, and holds an 8-bit register pointer.
- Master writes become one-cycle write strobes to a host register file; master reads return `rd_data` at the current pointer.
- The block is sampled entirely in the `clk` domain; SCL is input-only (no clock stretching).

Parameters:
- DEV_ADDR, 7'h38, 7-bit target address (write byte 0x70, read byte 0x71).

Ports:
- clk  input  1  system clock; must be at least 16x the SCL frequency.
- reset  input  1  asynchronous, active-low reset.
- scl_i  input  1  raw SCL pin level.
- sda_i  input  1  raw SDA pin level.
- sda_oe  output  1  1 = pull SDA low; 0 = release (pin tri-stated externally).
- wr_en  output  1  one-clk write strobe.
- wr_addr  output  8  register address qualified by wr_en.
- wr_data  output  8  data qualified by wr_en.
- rd_addr  output  8  equals the current pointer at all times.
- rd_data  input  8  register contents at rd_addr; combinational or one-clk registered.
- busy  output  1  high from START until STOP.
- addressed  output  1  high from address ACK until STOP or repeated START.

Behaviour:
- Reset (asynchronous on reset low): all outputs 0, pointer 0x00, state IDLE.
- Input synchronisers: scl_i and sda_i each pass through a 2-FF synchroniser (metastability flops) followed by one history flop. Edges are detected between the last synchroniser flop and the history flop.
- START: sda falls while scl is high. Legal in any state; goes to ADDR, bit count 0, sda_oe 0, busy 1, addressed 0. The pointer is kept (this supports repeated START).
- STOP: sda rises while scl is high. Legal in any state; goes to IDLE, sda_oe 0, busy 0, addressed 0. The pointer is kept.
- Bit timing:
  - SDA is sampled on the scl rising edge, MSB first.
  - sda_oe changes only on the clk after a detected scl falling edge, which preserves data hold time.
- States:
  - IDLE: ignore everything except START.
  - ADDR: shift in 8 bits.
    - On the 8th rising edge, if bits[7:1] == DEV_ADDR, go to ADDR_ACK with the rw bit latched; otherwise go to IGNORE.
  - ADDR_ACK: sda_oe = 1 from the falling edge after bit 8 until the next falling edge. At that falling edge, set addressed = 1.
    - rw = 0: go to PTR.
    - rw = 1: load shift register from rd_data and go to RDATA.
  - PTR: shift in 8 bits, load pointer, then PTR_ACK (ACK as above), then WDATA.
  - WDATA: shift in 8 bits.
    - On the clk after the 8th rising edge, pulse wr_en for one clk with wr_addr = pointer and wr_data = byte.
    - Then WDATA_ACK (ACK as above). At the end of the ACK, pointer increments and the state returns to WDATA.
  - RDATA: sda_oe = ~shift[7], updated after each falling edge. After 8 bits, sda_oe = 0 and the state goes to RDATA_ACK.
  - RDATA_ACK: sample SDA on the rising edge; pointer increments regardless of the sampled value.
    - SDA 0 (ACK): at the falling edge, load rd_data at the new pointer and return to RDATA.
    - SDA 1 (NACK): go to IGNORE.
  - IGNORE: sda_oe = 0; wait for START or STOP.
- Pointer arithmetic: 8-bit, wraps 0xFF -> 0x00 for both read and write auto-increment.
- STOP or START mid-byte: the partial byte is discarded, no wr_en is issued, and the pointer is not incremented.
- rd_data sampling: rd_data is sampled at least 2 clk after rd_addr changes.
- Reset asserted mid-transaction: sda_oe releases immediately (asynchronously). Bus activity is ignored until the next START.

Test Plan:
- Write transaction: START, 0x70, 0x25, 0xAA, STOP.
  - ACK (sda_oe = 1) during all three ACK slots.
  - Exactly one wr_en pulse, with wr_addr = 0x25 and wr_data = 0xAA.
  - Pointer = 0x26 after STOP; busy 1 -> 0.
- Combined read: START 0x70 0x42, repeated START 0x71, read 2 bytes (master ACK, then NACK), STOP.
  - rd_addr = 0x42 then 0x43; host model returns 0x5A then 0xC3.
  - SDA shows 0x5A then 0xC3; pointer = 0x44 after STOP.
- Address mismatch: START 0x72 0x10 0x55 STOP.
  - sda_oe stays 0 throughout; no wr_en; addressed stays 0.
- Wrap: write pointer 0xFF with data 0x11, 0x22.
  - wr_en at address 0xFF with 0x11, then at 0x00 with 0x22.
  - Pointer = 0x01 after STOP.
- Abort mid-byte: STOP after 4 data bits of the second data byte.
  - Only the first byte is written; state returns to IDLE.
  - A following START 0x70 is ACKed normally.
- Reset mid-ACK: pull reset low while sda_oe = 1.
  - sda_oe goes to 0 within the same clk and all outputs go to 0.
  - After release, the block ignores bus activity until the next START.

Source files
------------

// File: rtl/i2c_target.sv
// I2C target: START/STOP/repeated-START decode, 7-bit address match, 8-bit auto-incrementing register pointer.
// Latency: wr_en pulses one clk after the 8th data rising edge; SCL is never stretched, so no backpressure is possible.
module i2c_target #(
    parameter logic [6:0] DEV_ADDR = 7'h38
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    output logic       wr_en,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic [7:0] rd_addr,
    input  logic [7:0] rd_data,
    output logic       busy,
    output logic       addressed
);

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
        S_WDATA, S_WDATA_ACK, S_RDATA, S_RDATA_ACK, S_IGNORE
    } state_t;

    // [0],[1] metastability flops, [2] history flop
    logic [2:0] scl_sync_q, sda_sync_q;
    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] sh_q, sh_d;
    logic [7:0] ptr_q, ptr_d;
    logic       rw_q, rw_d;
    logic       oe_q, oe_d;
    logic       wr_en_q, wr_en_d;
    logic [7:0] wr_addr_q, wr_addr_d;
    logic [7:0] wr_data_q, wr_data_d;
    logic       addressed_q, addressed_d;

    logic scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;
    logic [7:0] byte_in;

    assign scl_s     = scl_sync_q[1];
    assign sda_s     = sda_sync_q[1];
    assign scl_rise  = scl_s & ~scl_sync_q[2];
    assign scl_fall  = ~scl_s & scl_sync_q[2];
    assign start_det = scl_s & ~sda_s & sda_sync_q[2];
    assign stop_det  = scl_s & sda_s & ~sda_sync_q[2];
    assign byte_in   = {sh_q[6:0], sda_s};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scl_sync_q  <= 3'b111;
            sda_sync_q  <= 3'b111;
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            sh_q        <= 8'h00;
            ptr_q       <= 8'h00;
            rw_q        <= 1'b0;
            oe_q        <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= 8'h00;
            wr_data_q   <= 8'h00;
            addressed_q <= 1'b0;
        end else begin
            scl_sync_q  <= {scl_sync_q[1:0], scl_i};
            sda_sync_q  <= {sda_sync_q[1:0], sda_i};
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sh_q        <= sh_d;
            ptr_q       <= ptr_d;
            rw_q        <= rw_d;
            oe_q        <= oe_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            addressed_q <= addressed_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sh_d        = sh_q;
        ptr_d       = ptr_q;
        rw_d        = rw_q;
        oe_d        = oe_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        addressed_d = addressed_q;

        if (start_det) begin
            state_d     = S_ADDR;
            cnt_d       = 4'd0;
            oe_d        = 1'b0;
            addressed_d = 1'b0;
        end else if (stop_det) begin
            state_d     = S_IDLE;
            oe_d        = 1'b0;
            addressed_d = 1'b0;
        end else begin
            case (state_q)
                S_ADDR, S_PTR, S_WDATA: begin
                    if (scl_rise) begin
                        sh_d  = byte_in;
                        cnt_d = cnt_q + 4'd1;
                        if (cnt_q == 4'd7) begin
                            cnt_d = 4'd0;
                            if (state_q == S_ADDR) begin
                                rw_d    = byte_in[0];
                                state_d = (byte_in[7:1] == DEV_ADDR) ? S_ADDR_ACK : S_IGNORE;
                            end else if (state_q == S_PTR) begin
                                ptr_d   = byte_in;
                                state_d = S_PTR_ACK;
                            end else begin
                                wr_en_d   = 1'b1;
                                wr_addr_d = ptr_q;
                                wr_data_d = byte_in;
                                state_d   = S_WDATA_ACK;
                            end
                        end
                    end
                end
                // First falling edge starts driving ACK, the second one ends the slot
                S_ADDR_ACK, S_PTR_ACK, S_WDATA_ACK: begin
                    if (scl_fall) begin
                        if (!oe_q) begin
                            oe_d = 1'b1;
                        end else begin
                            oe_d  = 1'b0;
                            cnt_d = 4'd0;
                            if (state_q == S_ADDR_ACK) begin
                                addressed_d = 1'b1;
                                if (rw_q) begin
                                    sh_d    = rd_data;
                                    oe_d    = ~rd_data[7];
                                    state_d = S_RDATA;
                                end else begin
                                    state_d = S_PTR;
                                end
                            end else if (state_q == S_PTR_ACK) begin
                                state_d = S_WDATA;
                            end else begin
                                ptr_d   = ptr_q + 8'd1;
                                state_d = S_WDATA;
                            end
                        end
                    end
                end
                S_RDATA: begin
                    if (scl_rise) begin
                        cnt_d = cnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (cnt_q == 4'd8) begin
                            oe_d    = 1'b0;
                            cnt_d   = 4'd0;
                            state_d = S_RDATA_ACK;
                        end else begin
                            sh_d = {sh_q[6:0], 1'b0};
                            oe_d = ~sh_q[6];
                        end
                    end
                end
                // cnt_q marks that the master's ACK bit has been sampled
                S_RDATA_ACK: begin
                    if (scl_rise) begin
                        ptr_d = ptr_q + 8'd1;
                        cnt_d = 4'd1;
                        if (sda_s) begin
                            state_d = S_IGNORE;
                        end
                    end else if (scl_fall && cnt_q != 4'd0) begin
                        sh_d    = rd_data;
                        oe_d    = ~rd_data[7];
                        cnt_d   = 4'd0;
                        state_d = S_RDATA;
                    end
                end
                S_IGNORE: begin
                    oe_d = 1'b0;
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    always_comb begin
        sda_oe    = oe_q;
        wr_en     = wr_en_q;
        wr_addr   = wr_addr_q;
        wr_data   = wr_data_q;
        rd_addr   = ptr_q;
        busy      = (state_q != S_IDLE);
        addressed = addressed_q;
    end

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: a bit-banged open-drain master, a host register model and a write monitor.
module tb_i2c_target;

    logic       clk = 1'b0;
    logic       reset;
    logic       scl_m, sda_m;
    logic       scl_i, sda_i;
    logic       sda_oe, wr_en, busy, addressed;
    logic [7:0] wr_addr, wr_data, rd_addr, rd_data;
    logic [7:0] mem [256];

    int n_chk  = 0;
    int n_fail = 0;

    logic [15:0] wr_log[$];
    int oe_cnt = 0;

    always #5 clk = ~clk;

    assign scl_i   = scl_m;
    assign sda_i   = sda_m & ~sda_oe;
    assign rd_data = mem[rd_addr];

    i2c_target #(.DEV_ADDR(7'h38)) dut (
        .clk       (clk),
        .reset     (reset),
        .scl_i     (scl_i),
        .sda_i     (sda_i),
        .sda_oe    (sda_oe),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .busy      (busy),
        .addressed (addressed)
    );

    always @(negedge clk) begin
        if (wr_en) wr_log.push_back({wr_addr, wr_data});
        if (sda_oe) oe_cnt++;
    end

    typedef struct {
        logic [7:0]        dev;
        logic [7:0]        ptr;
        logic [1:0][7:0]   d;
        int                nd;
        logic              exp_ack;
        logic [7:0]        exp_ptr;
        int                exp_nwr;
        logic [1:0][15:0]  exp_wr;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; tick(5);
        scl_m = 1'b1; tick(5);
        sda_m = 1'b0; tick(5);
        scl_m = 1'b0; tick(5);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; tick(5);
        scl_m = 1'b1; tick(5);
        sda_m = 1'b1; tick(5);
    endtask

    task automatic send_bit(input logic b);
        sda_m = b;    tick(5);
        scl_m = 1'b1; tick(10);
        scl_m = 1'b0; tick(5);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        sda_m = 1'b1; tick(5);
        scl_m = 1'b1; tick(5);
        ack = ~sda_i; tick(5);
        scl_m = 1'b0; tick(5);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        d = 8'h00;
        for (int i = 0; i < 8; i++) begin
            sda_m = 1'b1; tick(5);
            scl_m = 1'b1; tick(5);
            d = {d[6:0], sda_i}; tick(5);
            scl_m = 1'b0; tick(5);
        end
        send_bit(nack);
    endtask

    function automatic logic [15:0] log_at(input int idx);
        if (idx < wr_log.size()) return wr_log[idx];
        return 16'hDEAD;
    endfunction

    initial begin
        logic       ack;
        logic [7:0] rd;
        logic [7:0] b70;
        int         base, oe0;

        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hA5;
        mem[8'h42] = 8'h5A;
        mem[8'h43] = 8'hC3;
        b70 = 8'h70;

        vecs[0] = '{8'h70, 8'h25, {8'h00, 8'hAA}, 1, 1'b1, 8'h26, 1, {16'h0000, 16'h25AA}};
        vecs[1] = '{8'h72, 8'h10, {8'h00, 8'h55}, 1, 1'b0, 8'h26, 0, {16'h0000, 16'h0000}};
        vecs[2] = '{8'h70, 8'hFF, {8'h22, 8'h11}, 2, 1'b1, 8'h01, 2, {16'h0022, 16'hFF11}};
        vecs[3] = '{8'h70, 8'h7E, {8'h3C, 8'hC3}, 2, 1'b1, 8'h80, 2, {16'h7F3C, 16'h7EC3}};

        reset = 1'b0; scl_m = 1'b1; sda_m = 1'b1;
        tick(3);
        chk("rst_sda_oe", 32'(sda_oe), 32'd0);
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_addressed", 32'(addressed), 32'd0);
        chk("rst_rd_addr", 32'(rd_addr), 32'd0);
        chk("rst_wr_bus", 32'({wr_addr, wr_data}), 32'd0);
        reset = 1'b1;
        tick(5);

        // Write transactions, including address mismatch and pointer wrap
        for (int v = 0; v < 4; v++) begin
            base = wr_log.size();
            oe0  = oe_cnt;
            i2c_start();
            chk($sformatf("v%0d_busy_start", v), 32'(busy), 32'd1);
            write_byte(vecs[v].dev, ack);
            chk($sformatf("v%0d_addr_ack", v), 32'(ack), 32'(vecs[v].exp_ack));
            chk($sformatf("v%0d_addressed", v), 32'(addressed), 32'(vecs[v].exp_ack));
            write_byte(vecs[v].ptr, ack);
            chk($sformatf("v%0d_ptr_ack", v), 32'(ack), 32'(vecs[v].exp_ack));
            for (int k = 0; k < vecs[v].nd; k++) begin
                write_byte(vecs[v].d[k], ack);
                chk($sformatf("v%0d_data%0d_ack", v, k), 32'(ack), 32'(vecs[v].exp_ack));
            end
            i2c_stop();
            chk($sformatf("v%0d_busy_stop", v), 32'(busy), 32'd0);
            chk($sformatf("v%0d_addressed_stop", v), 32'(addressed), 32'd0);
            chk($sformatf("v%0d_ptr", v), 32'(rd_addr), 32'(vecs[v].exp_ptr));
            chk($sformatf("v%0d_nwr", v), 32'(wr_log.size() - base), 32'(vecs[v].exp_nwr));
            for (int k = 0; k < vecs[v].exp_nwr; k++)
                chk($sformatf("v%0d_wr%0d", v, k), 32'(log_at(base + k)), 32'(vecs[v].exp_wr[k]));
            chk($sformatf("v%0d_oe_any", v), 32'(oe_cnt != oe0), 32'(vecs[v].exp_ack));
        end

        // Combined read with repeated START
        base = wr_log.size();
        i2c_start();
        write_byte(8'h70, ack);
        chk("rd_wr_addr_ack", 32'(ack), 32'd1);
        write_byte(8'h42, ack);
        chk("rd_ptr_ack", 32'(ack), 32'd1);
        i2c_start();
        chk("rd_rstart_busy", 32'(busy), 32'd1);
        chk("rd_rstart_addressed", 32'(addressed), 32'd0);
        write_byte(8'h71, ack);
        chk("rd_addr_ack", 32'(ack), 32'd1);
        read_byte(1'b0, rd);
        chk("rd_byte0", 32'(rd), 32'h5A);
        chk("rd_ptr_mid", 32'(rd_addr), 32'h43);
        read_byte(1'b1, rd);
        chk("rd_byte1", 32'(rd), 32'hC3);
        chk("rd_nack_released", 32'(sda_oe), 32'd0);
        i2c_stop();
        chk("rd_ptr_end", 32'(rd_addr), 32'h44);
        chk("rd_no_writes", 32'(wr_log.size() - base), 32'd0);

        // STOP after four bits of the second data byte
        base = wr_log.size();
        i2c_start();
        write_byte(8'h70, ack);
        write_byte(8'h30, ack);
        write_byte(8'h77, ack);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        i2c_stop();
        chk("abort_nwr", 32'(wr_log.size() - base), 32'd1);
        chk("abort_wr0", 32'(log_at(base)), 32'h3077);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_ptr", 32'(rd_addr), 32'h31);
        i2c_start();
        write_byte(8'h70, ack);
        chk("abort_next_ack", 32'(ack), 32'd1);
        chk("abort_next_addressed", 32'(addressed), 32'd1);
        i2c_stop();
        chk("abort_next_ptr", 32'(rd_addr), 32'h31);

        // Reset while the target is driving the address ACK
        i2c_start();
        for (int i = 7; i >= 0; i--) send_bit(b70[i]);
        sda_m = 1'b1;
        tick(5);
        chk("rst_ack_driving", 32'(sda_oe), 32'd1);
        reset = 1'b0;
        #1;
        chk("rst_mid_sda_oe", 32'(sda_oe), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_addressed", 32'(addressed), 32'd0);
        chk("rst_mid_rd_addr", 32'(rd_addr), 32'd0);
        chk("rst_mid_wr_en", 32'(wr_en), 32'd0);
        tick(2);
        reset = 1'b1;
        tick(2);
        scl_m = 1'b1; tick(10);
        scl_m = 1'b0; tick(5);
        oe0 = oe_cnt;
        write_byte(8'h70, ack);
        chk("post_rst_no_ack", 32'(ack), 32'd0);
        chk("post_rst_busy", 32'(busy), 32'd0);
        write_byte(8'h12, ack);
        chk("post_rst_no_oe", 32'(oe_cnt - oe0), 32'd0);
        i2c_stop();
        base = wr_log.size();
        i2c_start();
        write_byte(8'h70, ack);
        chk("post_rst_addr_ack", 32'(ack), 32'd1);
        write_byte(8'h05, ack);
        write_byte(8'h99, ack);
        chk("post_rst_data_ack", 32'(ack), 32'd1);
        i2c_stop();
        chk("post_rst_wr", 32'(log_at(base)), 32'h0599);
        chk("post_rst_ptr", 32'(rd_addr), 32'h06);

        tick(10);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
